fetch_sequencer: RTL and testbench

- Owns the program counter and sequences instruction fetch for the single-issue pipeline.
- Each cycle it selects the next PC from four sources: reset vector, sequential PC+4, branch target and jump target.
- It applies stall and halt requests, inserts post-redirect bubbles, and marks each fetch slot valid or invalid for the IF/ID stage.
- Sits between the instruction-fetch datapath (PC register input, instruction memory address) and the hazard/branch-resolution logic in ID/EX.

---
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_fetch_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Program-counter owner and fetch-slot sequencer for the single-issue pipeline.
// Optional build macro FETCH_SEQ_STATS_EN adds saturating fetch/stall/redirect counters.
module fetch_sequencer #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0,
    parameter int                BUBBLES  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             fetch_valid,
    output logic             squash,
    output logic             halted,
    output logic             misalign
`ifdef FETCH_SEQ_STATS_EN
    ,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      redirect_cnt
`endif
);

    typedef enum logic [2:0] {BOOT, RUN, STALL, BUBBLE, HALT} state_t;

    state_t           state, state_n;
    logic [2:0]       bub_cnt, bub_cnt_n;
    logic             redirect, accept;
    logic [WIDTH-1:0] raw_target;

    assign redirect    = jmp | br_taken;
    assign raw_target  = jmp ? jmp_target : br_target;
    assign fetch_valid = (state == RUN) || (state == STALL);
    assign halted      = (state == HALT);
    assign squash      = accept;

    always_comb begin
        state_n   = state;
        bub_cnt_n = bub_cnt;
        pc_next   = pc;
        accept    = 1'b0;
        if (reset) begin
            pc_next   = RESET_PC;
            state_n   = BOOT;
            bub_cnt_n = '0;
        end else if (state == HALT) begin
            // redirects are dropped while halted; halt_req keeps us here
            if (!halt_req && resume)
                state_n = RUN;
        end else if (halt_req) begin
            state_n   = HALT;
            bub_cnt_n = '0;
        end else if (redirect) begin
            accept  = 1'b1;
            pc_next = {raw_target[WIDTH-1:2], 2'b00};
            if (BUBBLES > 0) begin
                state_n   = BUBBLE;
                bub_cnt_n = 3'(BUBBLES);
            end else begin
                state_n   = RUN;
                bub_cnt_n = '0;
            end
        end else begin
            case (state)
                BOOT: state_n = RUN;
                RUN, STALL: begin
                    if (stall) begin
                        state_n = STALL;
                    end else begin
                        state_n = RUN;
                        pc_next = pc + WIDTH'(4);
                    end
                end
                BUBBLE: begin
                    // a stall freezes the bubble countdown along with the PC
                    if (!stall) begin
                        pc_next   = pc + WIDTH'(4);
                        bub_cnt_n = bub_cnt - 3'd1;
                        if (bub_cnt <= 3'd1)
                            state_n = RUN;
                    end
                end
                default: state_n = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            state    <= BOOT;
            bub_cnt  <= '0;
            misalign <= 1'b0;
        end else begin
            pc       <= pc_next;
            state    <= state_n;
            bub_cnt  <= bub_cnt_n;
            if (accept && (raw_target[1:0] != 2'b00))
                misalign <= 1'b1;
        end
    end

`ifdef FETCH_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt    <= '0;
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (fetch_valid && (fetch_cnt != 32'hFFFF_FFFF))
                fetch_cnt <= fetch_cnt + 32'd1;
            if ((state == STALL) && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
            if (accept && (redirect_cnt != 32'hFFFF_FFFF))
                redirect_cnt <= redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: cycle-indexed stimulus, an abstract slot model
// checked every cycle, and hand-computed literal expectations at chosen cycles.
module tb_fetch_sequencer;
    localparam int NCYC = 38;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam int NBUB = 1;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, jmp, halt_req, resume;
    logic [31:0] br_target, jmp_target;
    logic [31:0] pc, pc_next;
    logic        fetch_valid, squash, halted, misalign;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit en = 1'b0;

    // abstract model: where the PC is, and why the slot might be empty
    logic [31:0] m_pc;
    bit          m_boot, m_halted, m_mis;
    int          m_bub;

    fetch_sequencer #(.WIDTH(32), .RESET_PC(RST_PC), .BUBBLES(NBUB)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jmp(jmp), .jmp_target(jmp_target),
        .halt_req(halt_req), .resume(resume),
        .pc(pc), .pc_next(pc_next), .fetch_valid(fetch_valid),
        .squash(squash), .halted(halted), .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic bit redirect_taken();
        return !reset && !m_halted && !halt_req && (jmp || br_taken);
    endfunction

    function automatic logic [31:0] model_next();
        if (reset) return RST_PC;
        if (m_halted || halt_req) return m_pc;
        if (jmp) return jmp_target & ~32'h3;
        if (br_taken) return br_target & ~32'h3;
        if (m_boot || stall) return m_pc;
        return m_pc + 32'd4;
    endfunction

    always @(posedge clk) begin
        logic [31:0] nxt;
        nxt = model_next();
        if (reset) begin
            m_boot = 1; m_halted = 0; m_mis = 0; m_bub = 0;
        end else if (m_halted) begin
            if (!halt_req && resume) m_halted = 0;
        end else if (halt_req) begin
            m_halted = 1; m_boot = 0; m_bub = 0;
        end else if (jmp || br_taken) begin
            m_boot = 0; m_bub = NBUB;
            if (((jmp ? jmp_target : br_target) & 32'h3) != 0) m_mis = 1;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (!stall && m_bub > 0) begin
            m_bub = m_bub - 1;
        end
        m_pc = nxt;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            chk("pc", pc, m_pc);
            chk("pc_next", pc_next, model_next());
            chk("fetch_valid", 32'(fetch_valid), 32'(!m_boot && !m_halted && m_bub == 0));
            chk("squash", 32'(squash), 32'(redirect_taken()));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("misalign", 32'(misalign), 32'(m_mis));
            case (cyc)
                0: begin chk("lit_pc", pc, 32'h0); chk("lit_fv", 32'(fetch_valid), 0);
                         chk("lit_halted", 32'(halted), 0); chk("lit_mis", 32'(misalign), 0);
                         chk("lit_squash", 32'(squash), 0); end
                1: begin chk("lit_pc", pc, 32'h0); chk("lit_fv", 32'(fetch_valid), 1); end
                2: chk("lit_pc", pc, 32'h4);
                3: chk("lit_pc", pc, 32'h8);
                5, 7: chk("lit_pc", pc, 32'h10);
                8: chk("lit_fv", 32'(fetch_valid), 1);
                9: chk("lit_pc", pc, 32'h14);
                12: begin chk("lit_pc", pc, 32'h20); chk("lit_squash", 32'(squash), 1); end
                13: begin chk("lit_pc", pc, 32'h100); chk("lit_fv", 32'(fetch_valid), 0); end
                14: begin chk("lit_pc", pc, 32'h104); chk("lit_fv", 32'(fetch_valid), 1);
                          chk("lit_squash", 32'(squash), 1); end
                15: chk("lit_pc", pc, 32'h200);
                16: chk("lit_mis", 32'(misalign), 0);
                17: begin chk("lit_pc", pc, 32'h100); chk("lit_mis", 32'(misalign), 1); end
                20: begin chk("lit_pc", pc, 32'hFFFF_FFFC); chk("lit_pc_next", pc_next, 32'h0);
                          chk("lit_mis", 32'(misalign), 1); end
                21: chk("lit_pc", pc, 32'h0);
                24: begin chk("lit_pc", pc, 32'h40); chk("lit_squash", 32'(squash), 0);
                          chk("lit_pc_next", pc_next, 32'h40); end
                25: begin chk("lit_halted", 32'(halted), 1); chk("lit_pc", pc, 32'h40);
                          chk("lit_fv", 32'(fetch_valid), 0); end
                26: chk("lit_squash", 32'(squash), 0);
                27: chk("lit_halted", 32'(halted), 1);
                28: begin chk("lit_pc", pc, 32'h40); chk("lit_fv", 32'(fetch_valid), 1);
                          chk("lit_halted", 32'(halted), 0); end
                29: chk("lit_pc", pc, 32'h44);
                32: chk("lit_squash", 32'(squash), 1);
                33: begin chk("lit_pc", pc, 32'h600); chk("lit_fv", 32'(fetch_valid), 0);
                          chk("lit_squash", 32'(squash), 0); chk("lit_pc_next", pc_next, 32'h0); end
                34: begin chk("lit_pc", pc, 32'h0); chk("lit_fv", 32'(fetch_valid), 0);
                          chk("lit_mis", 32'(misalign), 0); chk("lit_halted", 32'(halted), 0); end
                default: ;
            endcase
            cyc++;
        end
    end

    task automatic apply(input int c);
        stall = 0; br_taken = 0; jmp = 0; halt_req = 0; resume = 0; reset = 0;
        br_target = 32'h0; jmp_target = 32'h0;
        case (c)
            5, 6, 7: stall = 1;
            12: begin br_taken = 1; br_target = 32'h100; end
            14: begin jmp = 1; jmp_target = 32'h200; br_taken = 1; br_target = 32'h300; stall = 1; end
            16: begin br_taken = 1; br_target = 32'h103; end
            18: begin jmp = 1; jmp_target = 32'hFFFF_FFF8; end
            22: begin jmp = 1; jmp_target = 32'h3C; end
            24: begin halt_req = 1; br_taken = 1; br_target = 32'h80; end
            26: begin jmp = 1; jmp_target = 32'h90; end
            27: resume = 1;
            29: resume = 1;
            31: begin br_taken = 1; br_target = 32'h500; end
            32: begin jmp = 1; jmp_target = 32'h600; end
            33: reset = 1;
            default: ;
        endcase
    endtask

    initial begin
        apply(0);
        reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        en = 1;
        for (int c = 0; c < NCYC; c++) begin
            apply(c);
            @(posedge clk); #1;
        end
        en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
